mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, meaning cycles from MRead_request sampled to read_data valid; legal range 1..3.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports r0_req/r1_req, input, 1 each, requester wants an access.
REQ-005 SHALL have ports r0_we/r1_we, input, 1 each, 1 = write, 0 = read.
REQ-006 SHALL have ports r0_addr/r1_addr, input, 10 each, access address.
REQ-007 SHALL have ports r0_wdata/r1_wdata, input, 8 each, write data.
REQ-008 SHALL have ports r0_ack/r1_ack, output, 1 each, one-cycle completion pulse.
REQ-009 SHALL have ports r0_rdata/r1_rdata, output, 8 each, read result, valid with and after ack until that requester's next read completes.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have ports MRead_request/MWrite_request, output, 1 each, memory strobes.
REQ-012 SHALL have ports read_adress/write_adress, output, 10 each, and write_data, output, 8, memory address/data.
REQ-013 SHALL have port read_data, input, 8, memory read result.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE: if any req high, SHALL select a winner, latch its we/addr/wdata and requester id, and go to ISSUE; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester. On simultaneous requests the preferred one wins. After each completion the pointer SHALL point to the requester not just served.
REQ-017 ISSUE SHALL assert exactly one strobe for exactly one cycle, with latched address/data on the matching port. A write goes to DONE; a read goes to WAIT.
REQ-018 WAIT SHALL count READ_LAT cycles with a 2-bit counter. On the final count it SHALL capture read_data into the winner's rdata register and go to DONE.
REQ-019 DONE SHALL pulse the winner's ack for one cycle, update the pointer, and go to IDLE.
REQ-020 Latency, req sampled in IDLE to ack: write 2 cycles; read 2+READ_LAT cycles.
REQ-021 MRead_request and MWrite_request SHALL never be high in the same cycle and SHALL be low outside ISSUE.
REQ-022 Address/data outputs SHALL hold their last latched values outside ISSUE.
REQ-023 A requester SHALL hold req and its command stable until ack. It deasserts req in the cycle after ack or issues a new request.
REQ-024 A req dropped after being latched SHALL NOT abort the access; ack still pulses.
REQ-025 A losing requester SHALL be served next, before the winner is served again; no starvation.
REQ-026 Requests arriving while busy SHALL be ignored until IDLE.

Reset
REQ-027 When rst is low, SHALL force IDLE, pointer=0 (r0 preferred), counter=0, and all outputs to 0, asynchronously.
REQ-028 Reset mid-access SHALL abandon the access with no ack. A strobe in flight SHALL drop immediately.
REQ-029 After rst releases, the first arbitration SHALL occur on the first rising edge with rst high.

Verification
REQ-030 r0 write addr 5, data 20 -> one MWrite_request cycle at write_adress=5, write_data=20; r0_ack 2 cycles after req.
REQ-031 r1 read addr 5 with READ_LAT=1 and memory containing 20 -> one MRead_request at read_adress=5; r1_ack at cycle 3 with r1_rdata=20.
REQ-032 r0 and r1 request together after reset, both held high -> r0 served first, then r1. Repeat -> order r0, r1, r0, r1; never two consecutive grants to one requester while the other waits.
REQ-033 r0 write 33 to addr 10 concurrent with r1 read addr 10, r0 preferred -> write completes first, then r1_rdata=33. Strobes never overlap.
REQ-034 rst asserted during WAIT of a read -> busy=0, all strobes=0, and no ack immediately. After release, a pending r1 req is granted as a fresh access.
REQ-035 READ_LAT=3, r0 read -> ack exactly 5 cycles after req sampled; rdata equals read_data at the final WAIT cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory strobes
// shared by the arbiter and whatever drives it.
interface mem_arbiter_if;
  logic       r0_req, r1_req;
  logic       r0_we, r1_we;
  logic [9:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_ack, r1_ack;
  logic [7:0] r0_rdata, r1_rdata;
  logic       busy;
  logic       MRead_request, MWrite_request;
  logic [9:0] read_adress, write_adress;
  logic [7:0] write_data;
  logic [7:0] read_data;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  read_data,
    output r0_ack, r1_ack, r0_rdata, r1_rdata, busy,
    output MRead_request, MWrite_request, read_adress, write_adress, write_data
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output read_data,
    input  r0_ack, r1_ack, r0_rdata, r1_rdata, busy,
    input  MRead_request, MWrite_request, read_adress, write_adress, write_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port with a
// fixed read latency of READ_LAT cycles (1..3).
module mem_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       id_q, id_d;
  logic       we_q, we_d;
  logic [9:0] rd_addr_q, rd_addr_d;
  logic [9:0] wr_addr_q, wr_addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] r0_rdata_q, r0_rdata_d;
  logic [7:0] r1_rdata_q, r1_rdata_d;

  logic       gnt;
  logic       sel_we;
  logic [9:0] sel_addr;
  logic [7:0] sel_wdata;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    we_d       = we_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    // Preferred requester wins only on a tie; a lone requester always wins.
    gnt        = (bus.r0_req && bus.r1_req) ? ptr_q : bus.r1_req;
    sel_we     = gnt ? bus.r1_we    : bus.r0_we;
    sel_addr   = gnt ? bus.r1_addr  : bus.r0_addr;
    sel_wdata  = gnt ? bus.r1_wdata : bus.r0_wdata;

    case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          id_d = gnt;
          we_d = sel_we;
          if (sel_we) begin
            wr_addr_d = sel_addr;
            wdata_d   = sel_wdata;
          end else begin
            rd_addr_d = sel_addr;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 2'd0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          if (id_q) r1_rdata_d = bus.read_data;
          else      r0_rdata_d = bus.read_data;
          cnt_d   = 2'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        ptr_d   = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= 2'd0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      we_q       <= we_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end

  // Strobes and acks decode straight from the state so reset kills them at once.
  assign bus.MWrite_request = (state_q == ISSUE) &&  we_q;
  assign bus.MRead_request  = (state_q == ISSUE) && !we_q;
  assign bus.r0_ack         = (state_q == DONE)  && !id_q;
  assign bus.r1_ack         = (state_q == DONE)  &&  id_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.read_adress    = rd_addr_q;
  assign bus.write_adress   = wr_addr_q;
  assign bus.write_data     = wdata_q;
  assign bus.r0_rdata       = r0_rdata_q;
  assign bus.r1_rdata       = r1_rdata_q;

endmodule
